// File: rtl/stride_monitor_pkg.sv
// Shared definitions for the stride monitor: FSM state encoding.
package stride_monitor_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge CLK) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/stride_monitor.sv
// Checks that consecutive qualified samples of a counter step by STRIDE (mod 2^WIDTH),
// locks after LOCK_COUNT good deltas and latches a sticky fault on a violation while locked.
module stride_monitor
  import stride_monitor_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STRIDE     = 2,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8,
  parameter int CHECK_EVEN = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] delta,
  output logic             delta_valid,
  output logic             locked,
  output logic             fault,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] sample_count
);
  localparam logic [WIDTH-1:0] STRIDE_V = WIDTH'(STRIDE);
  localparam logic [7:0]       LOCK_V   = 8'(LOCK_COUNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev_sample;
  logic [7:0]       match_run;
  logic             srst;
  logic [WIDTH-1:0] diff;
  logic             bad, tracking, violation, good;

  assign srst      = RST | clr;
  assign diff      = in_data - prev_sample;
  assign bad       = (diff != STRIDE_V) || ((CHECK_EVEN != 0) && in_data[0]);
  assign tracking  = in_valid && (state != IDLE);
  assign violation = tracking && bad;
  assign good      = tracking && !bad;

  always_ff @(posedge CLK) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (in_valid) state_nxt = TRACK;
      TRACK:  if (good && ((match_run + 8'd1) >= LOCK_V)) state_nxt = LOCKED;
      LOCKED: if (violation) state_nxt = FAULT;
      FAULT:  state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
    fault  = (state == FAULT);
  end

  // Delta datapath; delta holds its last value when no sample arrives.
  always_ff @(posedge CLK) begin
    if (srst) begin
      prev_sample <= '0;
      match_run   <= '0;
      delta       <= '0;
      delta_valid <= 1'b0;
    end else begin
      delta_valid <= tracking;
      if (in_valid) prev_sample <= in_data;
      if (tracking) delta <= diff;
      if (in_valid && (state == TRACK)) begin
        if (bad)                    match_run <= '0;
        else if (match_run < LOCK_V) match_run <= match_run + 8'd1;
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .CLK (CLK),
    .clr (srst),
    .inc (violation),
    .cnt (err_count)
  );

  sat_counter #(.W(WIDTH)) u_sample_cnt (
    .CLK (CLK),
    .clr (srst),
    .inc (in_valid),
    .cnt (sample_count)
  );

  // Previous-cycle history for the err_count monotonicity property.
  logic [ERR_W-1:0] prev_err;
  logic             prev_srst;

  always_ff @(posedge CLK) begin
    prev_err  <= err_count;
    prev_srst <= srst;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(locked && fault));
      assert (!(delta_valid && locked) || (delta == STRIDE_V));
      assert (prev_srst || (err_count >= prev_err));
      assert (state <= FAULT);
    end
  end
endmodule

// File: doc/stride_monitor.md
Name: stride_monitor

Overview:
- Downstream consumer of a free-running even-stride counter: samples the counter value each qualified cycle and checks that consecutive samples differ by exactly STRIDE, modulo 2^WIDTH.
- Optionally checks that every sample is even.
- Locks after a run of good deltas and latches a sticky fault on any violation while locked.
- Carries Yosys-compatible immediate assertions so the counter-plus-monitor pair can be formally proven.

Parameters:
- WIDTH, 32: sample width in bits.
- STRIDE, 2: expected increment between consecutive samples.
- LOCK_COUNT, 4: number of consecutive good deltas required to lock; legal range 1..255.
- ERR_W, 8: error counter width; the counter saturates.
- CHECK_EVEN, 1: when 1, an odd sample counts as a violation.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  counter sample.
- in_valid  input  1  in_data is qualified this cycle.
- clr  input  1  synchronous soft clear; same effect as RST.
- delta  output  WIDTH  registered in_data − prev_sample, mod 2^WIDTH.
- delta_valid  output  1  one-cycle pulse; delta is meaningful.
- locked  output  1  high while in state LOCKED.
- fault  output  1  high while in state FAULT (sticky).
- err_count  output  ERR_W  saturating count of violations.
- sample_count  output  WIDTH  saturating count of accepted samples.

Behaviour:
- Reset (RST or clr):
  - state = IDLE; prev_sample = 0; match_run = 0.
  - All outputs 0.
  - RST/clr override a simultaneous in_valid; that sample is discarded.
- States: IDLE=0, TRACK=1, LOCKED=2, FAULT=3, 2-bit encoding.
- Sample acceptance:
  - Every in_valid sample is accepted in all states, including FAULT.
  - Each accepted sample sets prev_sample <= in_data and increments sample_count (saturating at all ones).
- IDLE:
  - in_valid: capture only; delta_valid stays 0; go to TRACK.
- TRACK / LOCKED / FAULT, on in_valid:
  - delta <= in_data − prev_sample, truncated to WIDTH; delta_valid <= 1.
  - Latency: 1 cycle from the sample to delta/delta_valid.
  - Violation = (delta ≠ STRIDE) OR (CHECK_EVEN and in_data[0] = 1).
- TRACK:
  - Good delta: match_run++.
  - When match_run reaches LOCK_COUNT: go to LOCKED, locked = 1 from the next cycle.
  - Violation: err_count++, match_run = 0, stay in TRACK.
- LOCKED:
  - Good delta: stay.
  - Violation: err_count++, go to FAULT; locked falls and fault rises on the same edge.
- FAULT:
  - Absorbing until RST or clr.
  - Deltas are still reported.
  - Further violations still increment err_count.
- Wrap-around: delta is mod 2^WIDTH, so 0xFFFF_FFFE → 0x0000_0000 with STRIDE=2 is a good delta, not a violation.
- err_count saturates at 2^ERR_W − 1 and never wraps.
- No in_valid: delta_valid = 0; delta holds its last value; state unchanged.
- match_run is 8 bits and saturates at LOCK_COUNT.
- Immediate assertions (no else clause), all gated by !RST:
  - locked and fault never both 1.
  - delta_valid && locked implies delta == STRIDE.
  - err_count is non-decreasing unless RST or clr was high the previous cycle.
  - state is always within 0..3.

Decomposition:
- Package stride_monitor_pkg:
  - State encoding constants IDLE, TRACK, LOCKED, FAULT.
  - STATE_W = 2.
- Sub-module sat_counter (params W, inputs inc/clr, output cnt), used for both err_count and sample_count.
- FSM and delta datapath stay in stride_monitor.

Test Plan:
- Reset then samples 0, 2, 4, 6, 8 on consecutive cycles:
  - delta = 2 with delta_valid on 4 cycles.
  - locked = 1 on the cycle after the delta of sample 8 is registered.
  - err_count = 0, sample_count = 5.
- Wrap: samples 0xFFFF_FFFA, FC, FE, 0x0, 0x2:
  - All deltas = 2.
  - locked = 1, fault = 0.
- Locked, then sample 13 after 10:
  - delta = 3, err_count = 1.
  - fault = 1 and locked = 0 on the same edge.
  - fault stays 1 through later good samples until clr.
- TRACK with odd samples 1, 3, 5 (CHECK_EVEN=1):
  - Deltas = 2 but err_count = 2.
  - Never locks.
  - With CHECK_EVEN=0 the same stimulus locks after LOCK_COUNT good deltas.
- in_valid and clr high in the same cycle while in FAULT:
  - Next cycle: state IDLE; all outputs 0; the sample is not counted.
- ERR_W=2 with 6 violations in TRACK:
  - err_count saturates at 3; the err_count monotonicity assertion holds.
  - Formal run (Yosys/SBY) of the counter feeding the monitor proves all assertions.
